// File: rtl/tm_arbiter.sv
// tm_arbiter: round-robin arbiter that time-shares one combinational 32x32
// signed tree multiplier among N_REQ requesters. Operands are latched on
// grant, presented to the multiplier for one cycle, and the 64-bit product
// is returned with the owning requester index over a valid/ready channel.
module tm_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*32-1:0]        req_a,
    input  logic [N_REQ*32-1:0]        req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic signed [31:0]         tm_a,
    output logic signed [31:0]         tm_b,
    input  logic signed [63:0]         tm_result,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic signed [63:0]         resp_result,
    output logic [ID_W-1:0]            resp_id,
    output logic                       busy,
    output logic [15:0]                op_count
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [ID_W-1:0]           last_grant;
    logic [ID_W-1:0]           win_idx;
    logic                      win_found;
    logic                      grant_window;
    logic                      grant_acc;
    logic                      vld_p0;
    logic signed [DATA_W-1:0]  op_a_p0;
    logic signed [DATA_W-1:0]  op_b_p0;
    logic [ID_W-1:0]           id_p0;

    // Requester index k positions after base, wrapping at N_REQ (k in 1..N_REQ).
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        return ID_W'(sum);
    endfunction

    // Round-robin search starting just after the last accepted grant.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!win_found && req_valid[rr_index(last_grant, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_index(last_grant, k);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: MUL is always one cycle; RESP waits for the consumer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = grant_acc ? MUL : IDLE;
            MUL:     state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = grant_acc ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grant window, one-hot ready, response valid and busy.
    always_comb begin
        resp_valid   = (state == RESP);
        busy         = (state != IDLE);
        vld_p0       = (state == MUL);
        grant_window = (state == IDLE) || ((state == RESP) && resp_ready);
        grant_acc    = grant_window && win_found && !rst;
        req_ready    = '0;
        if (grant_acc) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // The multiplier only ever sees latched operands.
    assign tm_a = op_a_p0;
    assign tm_b = op_b_p0;

    // Operand latch on grant, product capture in MUL, completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant  <= ID_W'(N_REQ - 1);
            op_a_p0     <= '0;
            op_b_p0     <= '0;
            id_p0       <= '0;
            resp_result <= '0;
            resp_id     <= '0;
            op_count    <= '0;
        end else begin
            // stage p0: winner operands latched
            if (grant_acc) begin
                op_a_p0    <= req_a[DATA_W*win_idx +: DATA_W];
                op_b_p0    <= req_b[DATA_W*win_idx +: DATA_W];
                id_p0      <= win_idx;
                last_grant <= win_idx;
            end
            // stage p1: product registered for the response channel
            if (vld_p0) begin
                resp_result <= tm_result;
                resp_id     <= id_p0;
            end
            if (resp_valid && resp_ready) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tm_arbiter.sv
// Directed bench for tm_arbiter with a behavioural multiplier model.
module tb_tm_arbiter;

    localparam int N = 4;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N*32-1:0]      req_a;
    logic [N*32-1:0]      req_b;
    logic [N-1:0]         req_ready;
    logic signed [31:0]   tm_a;
    logic signed [31:0]   tm_b;
    logic signed [63:0]   tm_result;
    logic signed [63:0]   ea;
    logic signed [63:0]   eb;
    logic                 resp_valid;
    logic                 resp_ready;
    logic signed [63:0]   resp_result;
    logic [1:0]           resp_id;
    logic                 busy;
    logic [15:0]          op_count;

    int          checks;
    int          failures;
    logic [15:0] exp_cnt;

    tm_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .tm_a       (tm_a),
        .tm_b       (tm_b),
        .tm_result  (tm_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_id    (resp_id),
        .busy       (busy),
        .op_count   (op_count)
    );

    // Behavioural tree multiplier: full 64-bit signed product.
    assign ea = {{32{tm_a[31]}}, tm_a};
    assign eb = {{32{tm_b[31]}}, tm_b};
    assign tm_result = ea * eb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        resp_ready = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
        checks++; if (resp_result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", resp_result); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", resp_id); end
        checks++; if (tm_a !== 32'd0 || tm_b !== 32'd0) begin failures++; $display("FAIL reset_tm got=%h/%h exp=0/0", tm_a, tm_b); end
        @(posedge clk); #1;
    endtask

    // One isolated multiply from IDLE with resp_ready high.
    task automatic do_single(input int id, input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid = '0;
        req_valid[id] = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'(1 << id)) begin failures++; $display("FAIL single_ready id=%0d got=%b exp=%b", id, req_ready, 4'(1 << id)); end
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL single_mul id=%0d busy=%b resp_valid=%b exp=1/0", id, busy, resp_valid); end
        checks++; if (tm_a !== a || tm_b !== b) begin failures++; $display("FAIL single_tm_ops id=%0d got=%h/%h exp=%h/%h", id, tm_a, tm_b, a, b); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_resp_valid id=%0d got=%b exp=1", id, resp_valid); end
        checks++; if (resp_result !== expv) begin failures++; $display("FAIL single_result id=%0d got=%h exp=%h", id, resp_result, expv); end
        checks++; if (resp_id !== 2'(id)) begin failures++; $display("FAIL single_id got=%0d exp=%0d", resp_id, id); end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        checks++; if (op_count !== exp_cnt) begin failures++; $display("FAIL single_op_count id=%0d got=%0d exp=%0d", id, op_count, exp_cnt); end
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle id=%0d resp_valid=%b busy=%b exp=0/0", id, resp_valid, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        do_single(0, 32'd50, -32'sd40, 64'hFFFF_FFFF_FFFF_F830);
    endtask

    task automatic test_signed_corners();
        do_single(1, -32'sd80, -32'sd65, 64'h0000_0000_0000_1450);
        do_single(2, -32'sd999, 32'sd999, 64'hFFFF_FFFF_FFF0_C58F);
        do_single(3, -32'sd10, 32'sd325, 64'hFFFF_FFFF_FFFF_F34E);
        do_single(0, 32'sd98765, 32'sd1, 64'h0000_0000_0001_81CD);
        do_single(1, 32'sd98756, 32'sd0, 64'h0000_0000_0000_0000);
    endtask

    task automatic test_round_robin();
        logic [63:0] rr_prod [4];
        int          k;
        logic [3:0]  exp_rdy;
        rr_prod[0] = 64'h0000_0000_0000_02BC;   //  100 *  7
        rr_prod[1] = 64'hFFFF_FFFF_FFFF_F9C0;   // -200 *  8
        rr_prod[2] = 64'hFFFF_FFFF_FFFF_F574;   //  300 * -9
        rr_prod[3] = 64'hFFFF_FFFF_FFFF_F060;   // -400 * 10
        req_a = {-32'sd400, 32'sd300, -32'sd200, 32'sd100};
        req_b = {32'sd10, -32'sd9, 32'sd8, 32'sd7};
        rst = 1'b1;
        req_valid = '1;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        exp_cnt = 16'd0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) req_valid = '0;
            @(negedge clk);
            exp_rdy = (c % 2 == 0 && c < 10) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready cycle=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            if (c % 2 == 0 && c >= 2) begin
                k = (c / 2 - 1) % 4;
                checks++; if (resp_valid !== 1'b1 || resp_id !== 2'(k)) begin failures++; $display("FAIL rr_resp cycle=%0d valid=%b id=%0d exp=1/%0d", c, resp_valid, resp_id, k); end
                checks++; if (resp_result !== rr_prod[k]) begin failures++; $display("FAIL rr_result cycle=%0d got=%h exp=%h", c, resp_result, rr_prod[k]); end
                checks++; if (op_count !== 16'(c / 2 - 1)) begin failures++; $display("FAIL rr_op_count cycle=%0d got=%0d exp=%0d", c, op_count, c / 2 - 1); end
            end else begin
                checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rr_resp_gap cycle=%0d got=%b exp=0", c, resp_valid); end
            end
            @(posedge clk); #1;
        end
        exp_cnt = 16'd5;
        @(negedge clk);
        checks++; if (op_count !== exp_cnt || busy !== 1'b0) begin failures++; $display("FAIL rr_end op_count=%0d busy=%b exp=%0d/0", op_count, busy, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid = 4'b0010;
        req_a[63:32] = 32'sd3;
        req_b[63:32] = -32'sd4;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_a[95:64] = -32'sd6;
        req_b[95:64] = -32'sd7;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_mul ready=%b resp_valid=%b exp=0000/0", req_ready, resp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready cycle=%0d got=%b exp=0000", i, req_ready); end
            checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== 64'hFFFF_FFFF_FFFF_FFF4) begin
                failures++; $display("FAIL bp_hold_resp cycle=%0d valid=%b id=%0d result=%h exp=1/1/fffffffffffffff4", i, resp_valid, resp_id, resp_result);
            end
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100 || resp_valid !== 1'b1 || resp_id !== 2'd1) begin
            failures++; $display("FAIL bp_release ready=%b valid=%b id=%0d exp=0100/1/1", req_ready, resp_valid, resp_id);
        end
        @(posedge clk); #1;
        req_valid = '0;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b1 || resp_id !== 2'd1) begin failures++; $display("FAIL bp_b2b_mul valid=%b busy=%b id=%0d exp=0/1/1", resp_valid, busy, resp_id); end
        checks++; if (op_count !== exp_cnt) begin failures++; $display("FAIL bp_op_count got=%0d exp=%0d", op_count, exp_cnt); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_result !== 64'sd42) begin
            failures++; $display("FAIL bp_second_resp valid=%b id=%0d result=%h exp=1/2/2a", resp_valid, resp_id, resp_result);
        end
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || op_count !== exp_cnt) begin failures++; $display("FAIL bp_done valid=%b op_count=%0d exp=0/%0d", resp_valid, op_count, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        req_a[31:0] = -32'sd500;
        req_b[31:0] = 32'sd2000;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL rmid_in_mul busy=%b ready=%b exp=1/0000", busy, req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 16'd0;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0) begin
            failures++; $display("FAIL rmid_ctrl valid=%b busy=%b op_count=%0d exp=0/0/0", resp_valid, busy, op_count);
        end
        checks++; if (tm_a !== 32'd0 || tm_b !== 32'd0 || resp_result !== 64'd0 || resp_id !== 2'd0) begin
            failures++; $display("FAIL rmid_data tm=%h/%h result=%h id=%0d exp=0", tm_a, tm_b, resp_result, resp_id);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_resp cycle=%0d got=%b exp=0", i, resp_valid); end
        end
        @(posedge clk); #1;
        req_a[127:96] = 32'sd5;
        req_b[127:96] = 32'sd5;
        req_valid = 4'b1001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_first_grant got=%b exp=0001", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 64'hFFFF_FFFF_FFF0_BDC0) begin
            failures++; $display("FAIL rmid_after_resp valid=%b id=%0d result=%h exp=1/0/fffffffffff0bdc0", resp_valid, resp_id, resp_result);
        end
        @(posedge clk); #1;
        exp_cnt = 16'd1;
        @(negedge clk);
        checks++; if (op_count !== exp_cnt) begin failures++; $display("FAIL rmid_op_count got=%0d exp=%0d", op_count, exp_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        force dut.op_count = 16'hFFFF;
        #2;
        release dut.op_count;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        checks++; if (op_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", op_count); end
        @(posedge clk); #1;
        do_single(2, -32'sd3, 32'sd3, 64'hFFFF_FFFF_FFFF_FFF7);
        checks++; if (op_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", op_count); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_cnt = 16'd0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single();
        test_signed_corners();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tm_arbiter.md
# tm_arbiter

Round-robin arbiter and sequencer that shares one combinational 32x32 signed tree multiplier (TM) among N_REQ requesters. Each requester presents signed operands over a valid/ready handshake. The arbiter latches the winner's operands, drives TM for one evaluation cycle and registers the 64-bit product. It returns the product with the requester index over a valid/ready response channel. The block sits between client datapaths and the single TM instance, and TM stays purely combinational.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester index
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_a  in  N_REQ*32  packed operand A, requester i at [32i+31:32i], two's complement
- req_b  in  N_REQ*32  packed operand B, same packing
- req_ready  out  N_REQ  one-hot grant/accept, combinational
- tm_a  out  32  operand A to TM
- tm_b  out  32  operand B to TM
- tm_result  in  64  signed product from TM, combinational from tm_a/tm_b
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_result  out  64  registered signed product
- resp_id  out  ID_W  index of the requester that owns resp_result
- busy  out  1  high in MUL or RESP
- op_count  out  16  completed-response counter, wraps at 16'hFFFF -> 0

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - MUL: latched operands drive TM.
  - RESP: the registered result is held until it is accepted.
- Grant window: state==IDLE, or state==RESP && resp_ready.
- In the grant window, req_ready is asserted only for the round-robin winner among the req_valid bits. In any other cycle req_ready is all zeros.
- Round-robin selection: search from (last_grant+1) mod N_REQ upward with wrap, and take the first set req_valid. last_grant updates only on an accepted grant.
- Accepted grant (req_valid[w] && req_ready[w]) latches the following and sets state to MUL:
  - op_a <= req_a[w], op_b <= req_b[w]
  - id_q <= w
- MUL lasts exactly 1 cycle. It captures resp_result <= tm_result and sets state to RESP.
- tm_a/tm_b = op_a/op_b in every state. TM never sees unlatched requester data.
- RESP handling:
  - resp_valid=1. resp_result and resp_id stay stable until resp_ready.
  - On a handshake op_count increments.
  - If a grant is also accepted in the same cycle, the next state is MUL. Otherwise it is IDLE.
- Product is the full 64-bit signed a*b. It never overflows, and no truncation or saturation is applied.
- Requester contract: once req_valid is high, it stays high with stable operands until req_ready. The arbiter does not check this.
- Requests not granted are held off and never dropped.

## Timing
- Reset values:
  - state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority)
  - op_a=op_b=0, so tm_a=tm_b=0
  - resp_result=0, resp_id=0, resp_valid=0
  - busy=0, op_count=0
- req_ready=0 throughout the reset cycle, regardless of req_valid.
- Latency: a grant accepted at edge T puts resp_valid high at T+2 (MUL at T+1, RESP at T+2).
- Throughput: with resp_ready held high and requests pending, one result every 2 cycles.
- Fairness: with all N_REQ continuously requesting, grants rotate 0,1,...,N_REQ-1,0,… with no requester granted twice before every other pending one is granted once.
- Simultaneous response handshake and new grant: both take effect at the same edge. resp_id and resp_result change only at the MUL->RESP edge.
- rst asserted mid-MUL or mid-RESP: the in-flight operation is discarded with no response, all registers return to reset values, and op_count clears.
- Back-pressure: resp_ready low holds RESP indefinitely, and req_ready stays 0 meanwhile.

## Test plan
- Single request: requester 0, a=50, b=-40 → req_ready[0] pulses 1 cycle; 2 cycles later resp_valid=1, resp_result=64'hFFFF_FFFF_FFFF_F830, resp_id=0; op_count=1 after accept.
- Signed corners: (-80,-65) → 64'h0000_0000_0000_1450; (-999,999) → 64'hFFFF_FFFF_FFF0_C58F; (-10,325) → 64'hFFFF_FFFF_FFFF_F34E; (98765,1) → 64'h0000_0000_0001_81CD; (98756,0) → 0.
- Round-robin: all 4 requesters valid from reset, resp_ready=1 → grant order 0,1,2,3,0; responses every 2 cycles; resp_id matches each requester's own product.
- Back-pressure: resp_ready=0 for 5 cycles with requester 2 pending → resp_result/resp_id stable, req_ready=0; on resp_ready=1 the grant to 2 occurs the same cycle and its resp_valid comes 2 cycles later.
- Reset mid-operation: rst asserted in the MUL cycle of a=-500,b=2000 → no response emitted; all outputs 0 the next cycle; requester 0 wins the first post-reset grant.
- op_count wrap: preload via 65535 responses (or force) → the next accept gives op_count=0.
